dmem_port_arbiter: RTL

Arbitrates the single data-memory port between the CPU memory stage and a DSP peripheral block-transfer engine. The CPU memory stage issues single-word loads and stores. The DSP engine issues auto-incrementing bursts of 1..2^BURST_W words. The CPU has priority and is stalled only when a DSP beat is forced by the starvation guard. The block sits between the memory stage, the DSP peripheral bus and the synchronous data RAM, which has one-cycle read latency.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_port_arbiter_if.sv | 60 ++++++
 rtl/dsp_burst_agen.sv | 48 ++++
 rtl/dmem_port_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory port arbiter:
//   dsp_state_e : DSP burst FSM states (D_IDLE / D_ACTIVE / D_DONE)
//   owner_e     : tag recording who owns the read data returning next cycle
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_ACTIVE = 2'd1,
        D_DONE   = 2'd2
    } dsp_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DSP  = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the three buses around the arbiter:
//   CPU memory stage : cpu_mem_read/write, cpu_addr, cpu_wdata -> cpu_stall,
//                      cpu_rvalid, cpu_rdata
//   DSP engine       : dsp_req/we/base/len/wdata -> dsp_busy, dsp_beat,
//                      dsp_rvalid, dsp_rdata, dsp_done
//   Data RAM         : mem_en/we/addr/wdata -> mem_rdata (1-cycle latency)
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding system (CPU, DSP engine and RAM)
// -----------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
);
    logic              cpu_mem_read;
    logic              cpu_mem_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic               dsp_req;
    logic               dsp_we;
    logic [ADDR_W-1:0]  dsp_base;
    logic [BURST_W-1:0] dsp_len;
    logic [DATA_W-1:0]  dsp_wdata;
    logic               dsp_busy;
    logic               dsp_beat;
    logic               dsp_rvalid;
    logic [DATA_W-1:0]  dsp_rdata;
    logic               dsp_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  dsp_req, dsp_we, dsp_base, dsp_len, dsp_wdata,
        output dsp_busy, dsp_beat, dsp_rvalid, dsp_rdata, dsp_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output dsp_req, dsp_we, dsp_base, dsp_len, dsp_wdata,
        input  dsp_busy, dsp_beat, dsp_rvalid, dsp_rdata, dsp_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dsp_burst_agen.sv
// -----------------------------------------------------------------------------
// dsp_burst_agen
// Address generator for DSP bursts. Latches base/len on load, counts beats
// on advance, and presents the current beat address (base + count, wrapping
// modulo 2^ADDR_W) together with a flag marking the final beat.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   load             : capture base/len and clear the beat counter
//   base, len        : burst start address, beats minus one
//   advance          : current beat was served
//   beat_addr        : address of the current beat
//   last_beat        : current beat is the last one (count == len)
// -----------------------------------------------------------------------------
module dsp_burst_agen #(
    parameter int ADDR_W  = 12,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [ADDR_W-1:0]  base,
    input  logic [BURST_W-1:0] len,
    input  logic               advance,
    output logic [ADDR_W-1:0]  beat_addr,
    output logic               last_beat
);
    logic [ADDR_W-1:0]  base_reg;
    logic [BURST_W-1:0] len_reg;
    logic [BURST_W-1:0] beat_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_reg     <= '0;
            len_reg      <= '0;
            beat_cnt_reg <= '0;
        end else if (load) begin
            base_reg     <= base;
            len_reg      <= len;
            beat_cnt_reg <= '0;
        end else if (advance) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
        end
    end

    // Natural truncation of the sum gives the required address wrap.
    assign beat_addr = base_reg + ADDR_W'(beat_cnt_reg);
    assign last_beat = (beat_cnt_reg == len_reg);
endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single synchronous data-RAM port between the CPU memory stage
// (single-word loads/stores, priority) and a DSP block-transfer engine
// (auto-incrementing bursts of dsp_len+1 beats).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset; aborts any burst in flight
//   bus   : dmem_port_arbiter_if.slave carrying CPU, DSP and RAM signals
// Build option:
//   DMEM_ARB_STARVE_GUARD_EN : when defined, the DSP wins the port after
//   WAIT_LIMIT consecutive lost cycles (stalling the CPU for that beat).
//   When undefined, the CPU has strict priority and cpu_stall is tied low.
// -----------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int BURST_W    = 4,
    parameter int WAIT_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);
    dsp_state_e        state_reg, state_next;
    owner_e            owner_reg, owner_next;
    logic              dsp_we_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] dsp_rdata_reg;

    logic              cpu_req;
    logic              cpu_grant;
    logic              dsp_grant;
    logic              forced;
    logic              active;
    logic              agen_load;
    logic              last_beat;
    logic [ADDR_W-1:0] beat_addr;

    assign cpu_req   = bus.cpu_mem_read | bus.cpu_mem_write;
    assign active    = (state_reg == D_ACTIVE);
    assign agen_load = (state_reg == D_IDLE) && bus.dsp_req;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_MAX = 4'(WAIT_LIMIT);
    logic [3:0] wait_cnt_reg;

    assign forced = active && (wait_cnt_reg == WAIT_MAX);

    always_ff @(posedge clk) begin
        if (reset || agen_load) begin
            wait_cnt_reg <= '0;
        end else if (active) begin
            if (dsp_grant)
                wait_cnt_reg <= '0;
            else if (wait_cnt_reg != WAIT_MAX)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    assign bus.cpu_stall = cpu_req & dsp_grant;
`else
    assign forced        = 1'b0;
    assign bus.cpu_stall = 1'b0;
`endif

    assign cpu_grant = cpu_req & ~forced;
    assign dsp_grant = ~cpu_grant & active;

    dsp_burst_agen #(
        .ADDR_W  (ADDR_W),
        .BURST_W (BURST_W)
    ) u_agen (
        .clk       (clk),
        .reset     (reset),
        .load      (agen_load),
        .base      (bus.dsp_base),
        .len       (bus.dsp_len),
        .advance   (dsp_grant),
        .beat_addr (beat_addr),
        .last_beat (last_beat)
    );

    // RAM command mux; everything reads zero on an idle port.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (cpu_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_mem_write;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (dsp_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = dsp_we_reg;
            bus.mem_addr  = beat_addr;
            bus.mem_wdata = bus.dsp_wdata;
        end
    end

    // A CPU cycle with both read and write asserted is a store only.
    always_comb begin
        owner_next = OWN_NONE;
        if (cpu_grant && bus.cpu_mem_read && !bus.cpu_mem_write)
            owner_next = OWN_CPU;
        else if (dsp_grant && !dsp_we_reg)
            owner_next = OWN_DSP;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            D_IDLE:   if (bus.dsp_req) state_next = D_ACTIVE;
            D_ACTIVE: if (dsp_grant && last_beat) state_next = D_DONE;
            D_DONE:   state_next = D_IDLE;
            default:  state_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= D_IDLE;
            owner_reg     <= OWN_NONE;
            dsp_we_reg    <= 1'b0;
            cpu_rdata_reg <= '0;
            dsp_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            if (agen_load)
                dsp_we_reg <= bus.dsp_we;
            if (owner_reg == OWN_CPU)
                cpu_rdata_reg <= bus.mem_rdata;
            if (owner_reg == OWN_DSP)
                dsp_rdata_reg <= bus.mem_rdata;
        end
    end

    // RAM data arrives the cycle after the grant, so the owner's rdata is a
    // bypass of mem_rdata; the hold registers keep the last value otherwise.
    assign bus.cpu_rvalid = (owner_reg == OWN_CPU);
    assign bus.dsp_rvalid = (owner_reg == OWN_DSP);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : cpu_rdata_reg;
    assign bus.dsp_rdata  = bus.dsp_rvalid ? bus.mem_rdata : dsp_rdata_reg;

    assign bus.dsp_busy = (state_reg != D_IDLE);
    assign bus.dsp_done = (state_reg == D_DONE);
    assign bus.dsp_beat = dsp_grant;
endmodule
